// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a row-major, channel-sequential Q6.10 stream.
// Horizontal pair maxima of even rows are parked in a half-width line buffer until the odd row arrives.
module maxpool2x2_stream #(
  parameter int MAX_W = 1024,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [10:0]   W,
  input  logic [10:0]   H,
  input  logic [10:0]   C,
  output logic          idle,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data
);

  localparam int LBD  = MAX_W / 2;
  localparam int LBAW = $clog2(LBD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q;
  logic [10:0]          wl_q, hl_q, cl_q;
  logic                 empty_q;
  logic [10:0]          col_q, row_q, ch_q;
  logic [10:0]          col_d, row_d, ch_d;
  logic signed [DW-1:0] pair_q;
  logic signed [DW-1:0] dout_data_q;
  logic                 dout_valid_q;
  logic signed [DW-1:0] lb [LBD];

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic                 in_xfer, out_xfer;
  logic                 col_in, row_in, col_last, row_last, ch_last;
  logic                 wr_lb, emit;
  logic [LBAW-1:0]      lb_idx;
  logic signed [DW-1:0] din_s, hmax, lb_rd, vmax;

  // Input is refused only while a finished result is still waiting downstream.
  assign din_ready = (state_q == S_RUN) && !empty_q && !(dout_valid_q && !dout_ready);
  assign in_xfer   = din_valid && din_ready;
  assign out_xfer  = dout_valid_q && dout_ready;

  assign col_in   = col_q < {wl_q[10:1], 1'b0};
  assign row_in   = row_q < {hl_q[10:1], 1'b0};
  assign col_last = col_q == (wl_q - 11'd1);
  assign row_last = row_q == (hl_q - 11'd1);
  assign ch_last  = ch_q == (cl_q - 11'd1);

  assign din_s  = $signed(din_data);
  assign lb_idx = col_q[LBAW:1];
  assign hmax   = smax(pair_q, din_s);
  assign lb_rd  = lb[lb_idx];
  assign vmax   = smax(lb_rd, hmax);
  assign wr_lb  = in_xfer && col_q[0] && col_in && !row_q[0] && row_in;
  assign emit   = in_xfer && col_q[0] && col_in &&  row_q[0] && row_in;

  always_comb begin
    col_d = col_q + 11'd1;
    row_d = row_q;
    ch_d  = ch_q;
    if (col_last) begin
      col_d = 11'd0;
      if (row_last) begin
        row_d = 11'd0;
        ch_d  = ch_q + 11'd1;
      end else begin
        row_d = row_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_lb) lb[lb_idx] <= hmax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wl_q         <= '0;
      hl_q         <= '0;
      cl_q         <= '0;
      empty_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      pair_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wl_q    <= W;
            hl_q    <= H;
            cl_q    <= C;
            empty_q <= (W == 11'd0) || (H == 11'd0) || (C == 11'd0);
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (empty_q) begin
            state_q <= S_DRAIN;
          end else if (in_xfer) begin
            if (!col_q[0] && col_in) pair_q <= din_s;
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
            if (ch_last && row_last && col_last) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!dout_valid_q || dout_ready) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase

      // A new result may load in the same cycle the previous one leaves.
      if (emit) begin
        dout_data_q  <= vmax;
        dout_valid_q <= 1'b1;
      end else if (out_xfer) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign idle       = (state_q == S_IDLE);
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: directed windows, random maps against a window-max model.
module tb_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [10:0] W, H, C;
  logic        idle, din_valid, din_ready, dout_valid, dout_ready;
  logic [15:0] din_data, dout_data;

  always #5 clk = ~clk;

  maxpool2x2_stream #(.MAX_W(1024), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .W(W), .H(H), .C(C), .idle(idle),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int in_cnt = 0;
  int out_cnt = 0;
  int rdy_mode = 0;      // 0 always ready, 1 random, 2 never ready
  bit noise_start = 0;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom_range(0, 1) == 1);
      default: dout_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, checks stall behaviour.
  bit          stalled = 0;
  logic [15:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", int'(dout_valid), 1);
        chk("stall_data", int'(dout_data), int'(held));
      end
      if (din_valid && din_ready) in_cnt++;
      if (dout_valid && !dout_ready) begin
        chk("din_ready_backpressure", int'(din_ready), 0);
        stalled = 1;
        held = dout_data;
      end else begin
        stalled = 0;
      end
      if (dout_valid && dout_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %0d, expected no output", $signed(dout_data));
        end else begin
          chk("dout", int'($signed(dout_data)), exp_q.pop_front());
        end
      end
    end
  end

  task automatic feed(input int v);
    int t;
    din_valid = 1'b1;
    din_data  = 16'(v);
    if (noise_start) begin
      start = 1'b1; W = 11'd2; H = 11'd2; C = 11'd5;
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (din_ready) break;
      t++;
      if (t > 2000) begin
        chk("din_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic do_start(input int w, input int h, input int c);
    @(posedge clk); #1;
    start = 1'b1; W = 11'(w); H = 11'(h); C = 11'(c);
    @(posedge clk); #1;
    start = 1'b0; W = 11'd3; H = 11'd3; C = 11'd3;
  endtask

  // Reference: every output is the max of its 2x2 window, tails discarded.
  task automatic model(input int d[], input int w, input int h, input int c);
    int b, m;
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < h / 2; r++)
        for (int cc = 0; cc < w / 2; cc++) begin
          b = ch * w * h + 2 * r * w + 2 * cc;
          m = d[b];
          if (d[b + 1] > m)     m = d[b + 1];
          if (d[b + w] > m)     m = d[b + w];
          if (d[b + w + 1] > m) m = d[b + w + 1];
          exp_q.push_back(m);
        end
  endtask

  // kind: 0 index, 1 negative index, 2 channel offset 100, 3 random (model), 4 small table
  task automatic run_job(input int w, input int h, input int c, input int kind);
    int n, t;
    int d[];
    int tbl[4];
    logic [15:0] r16;
    tbl = '{300, -7, 12, -500};
    n = w * h * c;
    d = new[n];
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: d[i] = i;
        1: d[i] = -(i + 1);
        2: d[i] = (i % (w * h)) + 100 * (i / (w * h));
        3: begin r16 = 16'($urandom); d[i] = int'($signed(r16)); end
        default: d[i] = tbl[i % 4];
      endcase
    end
    if (kind == 3) model(d, w, h, c);
    in_cnt = 0;
    out_cnt = 0;
    do_start(w, h, c);
    for (int i = 0; i < n; i++) begin
      if (kind == 3 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      feed(d[i]);
    end
    t = 0;
    while (!idle && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("job_returns_idle", int'(idle), 1);
    chk("inputs_accepted", in_cnt, n);
    chk("outputs_emitted", out_cnt, (w / 2) * (h / 2) * c);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; W = '0; H = '0; C = '0;
    din_valid = 1'b0; din_data = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_dout_data", int'(dout_data), 0);
    chk("reset_din_ready", int'(din_ready), 0);
    chk("reset_idle", int'(idle), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    rdy_mode = 0;
    exp_q.push_back(5);  exp_q.push_back(7);
    exp_q.push_back(13); exp_q.push_back(15);
    run_job(4, 4, 1, 0);

    exp_q.push_back(-1); exp_q.push_back(-3);
    run_job(5, 3, 1, 1);

    exp_q.push_back(5);   exp_q.push_back(7);
    exp_q.push_back(105); exp_q.push_back(107);
    run_job(4, 2, 2, 2);

    rdy_mode = 1;
    run_job(8, 8, 3, 3);
    run_job(7, 5, 2, 3);

    // Abort a job while a result is held, then restart cleanly.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    do_start(4, 4, 1);
    for (int i = 0; i < 6; i++) feed(i);
    @(negedge clk);
    chk("held_valid_before_reset", int'(dout_valid), 1);
    chk("held_data_before_reset", int'(dout_data), 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_dout_valid", int'(dout_valid), 0);
    chk("abort_idle", int'(idle), 1);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (4) begin
      @(negedge clk);
      chk("no_partial_output", int'(dout_valid), 0);
    end
    exp_q.push_back(300);
    run_job(2, 2, 1, 4);

    noise_start = 1;
    run_job(1, 4, 2, 0);
    noise_start = 0;

    run_job(3, 3, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the convolution core.
- Consumes the core's output stream: 16-bit signed Q6.10 values, row-major within a channel, channel after channel.
- Emits the pooled map in the same order and format to the next stage or writeback.
- Uses one line buffer of horizontal pair maxima, so each input is read exactly once.

Parameters:
- MAX_W, 1024, largest supported input row width; line buffer depth is MAX_W/2.
- DW, 16, data width (signed fixed point, Q6.10).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse in S_IDLE; latches W, H, C and begins a job
- W  input  11  input map width (columns), 1..MAX_W
- H  input  11  input map height (rows)
- C  input  11  channel count
- idle  output  1  high in S_IDLE
- din_valid  input  1  upstream data valid
- din_ready  output  1  this block accepts din_data this cycle
- din_data  input  DW  input element
- dout_valid  output  1  pooled element valid
- dout_ready  input  1  downstream accepts
- dout_data  output  DW  pooled element

Behaviour:
- Reset (synchronous, active-high): state=S_IDLE, dout_valid=0, dout_data=0, din_ready=0, idle=1; col, row, ch and pair register cleared. Line buffer contents are don't-care.
- Reset mid-job aborts immediately to the same values; no partial output is emitted afterwards.
- Transfers:
  - Input transfer when din_valid && din_ready.
  - Output transfer when dout_valid && dout_ready.
  - dout_valid, once set, holds with dout_data stable until the transfer.
- Latched config: Wl, Hl, Cl are taken at start; the W/H/C ports are ignored afterwards.
- Output size: Wo=floor(Wl/2), Ho=floor(Hl/2). An odd last column or odd last row is consumed but discarded.
- States:
  - S_IDLE: start -> S_RUN; all counters cleared.
  - S_RUN:
    - din_ready = !(dout_valid && !dout_ready).
    - On each input transfer, position (col,row) within channel ch:
      - col even, col<2*Wo: pair <= din_data.
      - col odd, row even, row<2*Ho: lb[col>>1] <= smax(pair, din_data).
      - col odd, row odd, row<2*Ho: dout_data <= smax(lb[col>>1], smax(pair, din_data)), dout_valid <= 1.
      - Otherwise (odd tail column or odd tail row): element dropped.
    - Counter advance: col wraps at Wl-1 to 0 and increments row; row wraps at Hl-1 to 0 and increments ch.
    - Last input (ch=Cl-1, row=Hl-1, col=Wl-1) -> S_DRAIN.
  - S_DRAIN: din_ready=0; when dout_valid=0 or the output transfer occurs this cycle -> S_DONE.
  - S_DONE: one cycle, din_ready=0 -> S_IDLE.
- Same-cycle input and output: if the output register frees in the cycle a new result is computed, the new result loads and dout_valid stays 1.
- Output timing: result is registered; dout_valid rises the cycle after the 4th window element is accepted. Throughput is one input per cycle while downstream is ready.
- smax is a signed compare; ties select either operand (values are identical).
- start outside S_IDLE is ignored.
- Degenerate sizes:
  - Wl<2 or Hl<2 with Cl>=1: consumes Wl*Hl*Cl inputs, emits nothing, finishes through S_DONE.
  - Cl=0, Wl=0 or Hl=0: S_RUN -> S_DRAIN the cycle after start with no input accepted.
- Backpressure: all counters hold while din_ready=0. The line buffer is never overwritten before it is read, because a pixel's row pair completes within the same channel.

Test Plan:
- W=4,H=4,C=1, inputs 0..15 (Q6.10 integers), dout_ready=1 -> outputs 5,7,13,15 in order; 4 outputs then S_DONE, idle after.
- W=5,H=3,C=1, all inputs negative (-1..-15) -> outputs smax over the windows: -1 then -3 (col 4 and row 2 dropped); 15 inputs accepted.
- W=4,H=2,C=2, channel 1 = channel 0 + 100 -> 4 outputs; outputs 3-4 exceed outputs 1-2 by 100; no cross-channel mixing.
- Random dout_ready (~50% duty), W=8,H=8,C=3 -> 48 outputs identical to the golden model; din_ready low whenever dout_valid && !dout_ready; dout_data stable while stalled.
- Assert rst while dout_valid=1 mid-job -> next cycle dout_valid=0, idle=1; a following start with W=2,H=2,C=1 produces exactly one correct output.
- W=1,H=4,C=2 -> 8 inputs accepted, zero outputs, returns to idle; start pulses during S_RUN are ignored.
